cv32e40n_apu_responder: RTL and testbench

Parametrised, pipelined APU responder that plugs into the cv32e40p APU request/response channel as a stand-in coprocessor. It accepts up to DEPTH outstanding requests and returns each result exactly LATENCY cycles after grant, in order. It computes a small deterministic result set so the core datapath can be checked end to end. It also drives the memory-master select with an explicit release handshake.

---
 rtl/cv32e40n_apu_responder.sv | 121 ++++++++++++
 tb/tb_cv32e40n_apu_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40n_apu_responder.sv
// Stand-in APU coprocessor: fixed-latency, in-order result pipeline with a
// bounded in-flight count and a sticky memory-master select.
module cv32e40n_apu_responder #(
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5,
  parameter int LATENCY  = 2,
  parameter int DEPTH    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NARGS-1:0][31:0]    apu_operands_i,
  input  logic [WOP-1:0]            apu_op_i,
  input  logic [NDSFLAGS-1:0]       apu_flags_i,
  input  logic                      apu_req_i,
  output logic                      apu_gnt_o,
  output logic                      apu_rvalid_o,
  output logic [31:0]               apu_result_o,
  output logic [NUSFLAGS-1:0]       apu_flags_o,
  output logic                      mem_master_sel_o,
  input  logic                      mem_release_i,
  output logic                      busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LATENCY-1:0]               vld_pipe;
  logic [LATENCY-1:0][31:0]         res_pipe;
  logic [LATENCY-1:0][NUSFLAGS-1:0] flg_pipe;
  logic [CW-1:0]                    cnt_q;
  logic                             accept;
  logic                             rvalid;
  logic [32:0]                      sum;
  logic [31:0]                      res_d;
  logic [NUSFLAGS-1:0]              flg_d;
  logic                             unused_inputs;

  // Operand slots above [1], opcode bits above [1:0] and the downstream flags
  // carry no meaning for this responder.
  assign unused_inputs = ^{apu_flags_i, apu_op_i, apu_operands_i};

  assign apu_gnt_o = (cnt_q < DEPTH_C);
  assign accept    = apu_req_i & apu_gnt_o;
  assign rvalid    = vld_pipe[LATENCY-1];
  assign sum       = {1'b0, apu_operands_i[0]} + {1'b0, apu_operands_i[1]};

  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (apu_op_i[1:0])
      2'd0: begin
        res_d    = sum[31:0];
        flg_d[1] = sum[32];
      end
      2'd1:    res_d = apu_operands_i[0];
      2'd2:    res_d = apu_operands_i[0] ^ apu_operands_i[1];
      default: res_d = apu_operands_i[0] & apu_operands_i[1];
    endcase
    flg_d[0] = (res_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[0] <= 1'b0;
      res_pipe[0] <= '0;
      flg_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= accept;
      if (accept) begin
        res_pipe[0] <= res_d;
        flg_pipe[0] <= flg_d;
      end
    end
  end

  // Stages past the first shift unconditionally; there is no backpressure.
  for (genvar s = 1; s < LATENCY; s++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_pipe[s] <= 1'b0;
        res_pipe[s] <= '0;
        flg_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        res_pipe[s] <= res_pipe[s-1];
        flg_pipe[s] <= flg_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({accept, rvalid})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A new memory-op accept outranks a release arriving in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_master_sel_o <= 1'b0;
    end else if (accept && (apu_op_i[1:0] == 2'd1)) begin
      mem_master_sel_o <= 1'b1;
    end else if (mem_release_i) begin
      mem_master_sel_o <= 1'b0;
    end
  end

  assign apu_rvalid_o = rvalid;
  assign apu_result_o = rvalid ? res_pipe[LATENCY-1] : '0;
  assign apu_flags_o  = rvalid ? flg_pipe[LATENCY-1] : '0;
  assign busy_o       = (cnt_q != '0);

endmodule

// File: tb/tb_cv32e40n_apu_responder.sv
// Bench for cv32e40n_apu_responder: three configurations share one stimulus
// stream and are each checked every cycle against a queue-based response model.
module tb_cv32e40n_apu_responder;

  localparam int LAT [3] = '{2, 3, 1};
  localparam int DEP [3] = '{4, 2, 1};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [5:0]       op = '0;
  logic [2:0][31:0] operands = '0;
  logic [14:0]      dsflags = '0;
  logic             mem_rel = 1'b0;

  logic [2:0]       gnt, rvalid, sel, busy;
  logic [2:0][31:0] result;
  logic [2:0][4:0]  flags;

  always #5 clk = ~clk;

  cv32e40n_apu_responder #(.LATENCY(2), .DEPTH(4)) u_l2d4 (
    .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(operands), .apu_op_i(op),
    .apu_flags_i(dsflags), .apu_req_i(req), .apu_gnt_o(gnt[0]),
    .apu_rvalid_o(rvalid[0]), .apu_result_o(result[0]), .apu_flags_o(flags[0]),
    .mem_master_sel_o(sel[0]), .mem_release_i(mem_rel), .busy_o(busy[0]));

  cv32e40n_apu_responder #(.LATENCY(3), .DEPTH(2)) u_l3d2 (
    .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(operands), .apu_op_i(op),
    .apu_flags_i(dsflags), .apu_req_i(req), .apu_gnt_o(gnt[1]),
    .apu_rvalid_o(rvalid[1]), .apu_result_o(result[1]), .apu_flags_o(flags[1]),
    .mem_master_sel_o(sel[1]), .mem_release_i(mem_rel), .busy_o(busy[1]));

  cv32e40n_apu_responder #(.LATENCY(1), .DEPTH(1)) u_l1d1 (
    .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(operands), .apu_op_i(op),
    .apu_flags_i(dsflags), .apu_req_i(req), .apu_gnt_o(gnt[2]),
    .apu_rvalid_o(rvalid[2]), .apu_result_o(result[2]), .apu_flags_o(flags[2]),
    .mem_master_sel_o(sel[2]), .mem_release_i(mem_rel), .busy_o(busy[2]));

  typedef struct {
    int unsigned due;
    logic [31:0] res;
    logic [4:0]  flg;
  } resp_t;

  resp_t       mq [3][$];
  bit          msel [3];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic [4:0] f);
    longint s;
    s = longint'(a) + longint'(b);
    f = '0;
    case (o)
      2'd0: begin
        r    = s[31:0];
        f[1] = (s > 64'h0000_0000_FFFF_FFFF);
      end
      2'd1:    r = a;
      2'd2:    r = a ^ b;
      default: r = a & b;
    endcase
    f[0] = (r == 32'd0);
  endfunction

  function automatic logic [40:0] exp_out(int k);
    logic v;
    logic [31:0] r;
    logic [4:0] f;
    v = 1'b0; r = '0; f = '0;
    if (mq[k].size() != 0) begin
      if (mq[k][0].due == cyc) begin
        v = 1'b1; r = mq[k][0].res; f = mq[k][0].flg;
      end
    end
    return {(mq[k].size() < DEP[k]), v, r, f, msel[k], (mq[k].size() != 0)};
  endfunction

  function automatic logic [40:0] obs(int k);
    return {gnt[k], rvalid[k], result[k], flags[k], sel[k], busy[k]};
  endfunction

  task automatic model_step();
    logic [31:0] r;
    logic [4:0]  f;
    bit          acc;
    for (int k = 0; k < 3; k++) begin
      acc = req && (mq[k].size() < DEP[k]);
      if (mq[k].size() != 0 && mq[k][0].due == cyc) void'(mq[k].pop_front());
      if (acc) begin
        ref_calc(op[1:0], operands[0], operands[1], r, f);
        mq[k].push_back('{cyc + LAT[k], r, f});
      end
      if (acc && op[1:0] == 2'd1) msel[k] = 1'b1;
      else if (mem_rel) msel[k] = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    req = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      msel[k] = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      dsflags = 15'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL in_reset u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      req = 1'b0; op = 6'($urandom); dsflags = 15'($urandom);
      operands = {$urandom, $urandom, $urandom};
      mem_rel = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL reset_idle u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      checks++;
      if (obs(0) !== 41'h100_0000_0000) begin
        errors++;
        $display("FAIL reset_values got=%h exp=%h", obs(0), 41'h100_0000_0000);
      end
      model_step(); @(posedge clk); #1;
    end
  endtask

  task automatic test_single_add();
    mem_rel = 1'b0;
    for (int n = 0; n < 6; n++) begin
      req = (n == 0); op = {4'($urandom), 2'd0}; dsflags = 15'($urandom);
      operands = {$urandom, 32'd1, 32'hFFFF_FFFF};
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL single_add u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      checks++;
      if (rvalid[0] !== (n == 2)) begin
        errors++;
        $display("FAIL add_rvalid_timing n=%0d got=%b exp=%b", n, rvalid[0], (n == 2));
      end
      if (n == 2) begin
        checks++;
        if ({result[0], flags[0]} !== {32'd0, 5'b00011}) begin
          errors++;
          $display("FAIL add_wrap got=%h/%b exp=0/00011", result[0], flags[0]);
        end
      end
      if (n == 3) begin
        checks++;
        if (busy[0] !== 1'b0) begin
          errors++;
          $display("FAIL add_busy_clear got=%b exp=0", busy[0]);
        end
      end
      model_step(); @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    logic [1:0]  seq [3] = '{2'd2, 2'd3, 2'd0};
    logic [31:0] expv [3] = '{32'h0000_00F0, 32'h0000_000F, 32'h0000_010E};
    logic [31:0] got [$];
    int unsigned acc_c [3];
    int idx = 0;
    for (int n = 0; n < 14; n++) begin
      req = (idx < 3);
      op = {4'($urandom), (idx < 3) ? seq[idx] : 2'd0};
      operands = {$urandom, 32'h0000_00FF, 32'h0000_000F};
      dsflags = 15'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL full u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      if (rvalid[1]) got.push_back(result[1]);
      if (req && gnt[1] && idx < 3) begin acc_c[idx] = cyc; idx++; end
      model_step(); @(posedge clk); #1;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL full_accepts got=%0d exp=3", idx);
    end else begin
      checks++;
      if (acc_c[1] - acc_c[0] != 1 || acc_c[2] - acc_c[0] != 4) begin
        errors++;
        $display("FAIL full_gnt_timing got=+%0d,+%0d exp=+1,+4",
                 acc_c[1] - acc_c[0], acc_c[2] - acc_c[0]);
      end
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL full_resp_count got=%0d exp=3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== expv[i]) begin
          errors++;
          $display("FAIL full_order i=%0d got=%h exp=%h", i, got[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [4:0] exp_sel = 5'b00010;
    for (int n = 0; n < 5; n++) begin
      req = (n == 0); op = {4'($urandom), 2'd1}; mem_rel = (n < 2);
      operands = {$urandom, $urandom, $urandom};
      dsflags = 15'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL mem u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      checks++;
      if (sel[0] !== exp_sel[n]) begin
        errors++;
        $display("FAIL mem_sel n=%0d got=%b exp=%b", n, sel[0], exp_sel[n]);
      end
      model_step(); @(posedge clk); #1;
    end
    mem_rel = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 2; n++) begin
      req = 1'b1; op = 6'($urandom); operands = {$urandom, $urandom, $urandom};
      dsflags = 15'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL pre_reset u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      model_step(); @(posedge clk); #1;
    end
    do_reset();
    for (int n = 0; n < 5; n++) begin
      req = 1'b0; dsflags = 15'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL post_reset u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      checks++;
      if ({gnt[0], rvalid[0], busy[0]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_drop n=%0d got gnt/rv/busy=%b exp=100", n, {gnt[0], rvalid[0], busy[0]});
      end
      model_step(); @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      req = (n < 20); op = 6'($urandom); operands = {$urandom, $urandom, $urandom};
      dsflags = 15'($urandom); mem_rel = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL back_to_back u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      model_step(); @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      req = ($urandom_range(0, 9) < 7); op = 6'($urandom);
      operands = {$urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom};
      dsflags = 15'($urandom); mem_rel = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL random u%0d cyc=%0d got=%h exp=%h", k, cyc, obs(k), exp_out(k));
        end
      end
      model_step(); @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_full();
    test_mem();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
